ocram_stream_reader: RTL and testbench
======================================

Name: ocram_stream_reader

Overview:
- Read engine sitting directly in front of the 8192 x 16 single-port on-chip RAM.
- Accepts a (start address, length) command and drives the RAM's address/chipselect/byteenable port, one read per cycle; the RAM returns data one cycle after the address.
- Returns the words on a valid/ready streaming output with start-of-packet and end-of-packet markers.
- A small internal FIFO with credit-based issue absorbs downstream backpressure without losing in-flight read data.

Parameters:
- ADDR_W, 13, RAM word-address width (8192 words).
- DATA_W, 16, RAM data width.
- LEN_W, 14, command length width; legal lengths 0..8192.
- FIFO_DEPTH, 4, output buffer depth in words; power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle, command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  ADDR_W  first word address.
- cmd_len  in  LEN_W  number of words to read.
- ram_address  out  ADDR_W  RAM address.
- ram_chipselect  out  1  RAM select, high only on issue cycles.
- ram_write  out  1  tied 0.
- ram_byteenable  out  DATA_W/8  tied all-ones.
- ram_clken  out  1  tied 1.
- ram_readdata  in  DATA_W  RAM read data, valid one cycle after an issue.
- st_data  out  DATA_W  stream data.
- st_valid  out  1  stream data valid.
- st_ready  in  1  downstream accept.
- st_sop  out  1  first word of the command.
- st_eop  out  1  last word of the command.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when the last word has been accepted downstream.

Behaviour:
- Reset (async, any cycle, including mid-command):
  - FSM returns to IDLE.
  - FIFO is emptied and the in-flight flag is cleared.
  - Outputs: cmd_ready=1, st_valid=0, st_sop=0, st_eop=0, busy=0, done=0, ram_chipselect=0, ram_address=0.
  - The partially delivered packet is dropped.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On accept, latch addr and len, then go to READ. If len=0, go to DONE instead.
  - READ: issue reads. After the last issue, go to DRAIN.
  - DRAIN: wait until there is no in-flight read and the FIFO is empty, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
  - busy=1 in READ, DRAIN and DONE.
- Issue rule:
  - In READ, a read issues in a cycle where (fifo_count + inflight) < FIFO_DEPTH.
  - On an issue cycle: ram_chipselect=1, ram_address=current address.
  - After each issue: current address increments modulo 2^ADDR_W (8191 wraps to 0) and remaining count decrements.
  - inflight is a 1-bit flag set on an issue cycle.
- Capture:
  - In the cycle after an issue, ram_readdata is pushed into the FIFO at the clock edge.
  - sop/eop tags are pushed with the data: sop on the first word, eop when remaining was 1 at issue.
- Latency:
  - Accept at edge E0; first issue in the cycle after E0.
  - First st_valid two cycles after the first issue.
  - With st_ready held high, throughput is 1 word/cycle with no gaps.
- Stream rule:
  - st_valid = FIFO non-empty; st_data, st_sop and st_eop come from the FIFO head.
  - Pop on st_valid & st_ready.
  - st_data must stay stable while st_valid & !st_ready.
- Simultaneous push and pop on the same cycle: occupancy is unchanged. A push into a full FIFO cannot occur because of the credit rule; the verification bench asserts this.
- cmd_len=8192 reads the whole RAM, wrapping to the start address.
- cmd_valid is ignored while busy.

Decomposition:
- Shared package ocram_pkg:
  - constants OCRAM_ADDR_W=13, OCRAM_DATA_W=16, OCRAM_DEPTH=8192;
  - FSM state enum {IDLE, READ, DRAIN, DONE}.
- One sub-module: ocram_sync_fifo.
  - Synchronous FIFO, width DATA_W+2 (data, sop, eop), depth FIFO_DEPTH.
  - Outputs count, empty and full; async reset.

Test Plan:
- Load RAM[i]=i^16'hA5A5. Issue cmd addr=0x0010, len=4 with st_ready=1 -> st_data A5B5, A5B4, A5B7, A5B6; sop on beat 1 and eop on beat 4; first st_valid 3 cycles after accept; done 1 cycle after the last beat.
- Issue cmd addr=0x1FFE, len=4 -> ram_address sequence 1FFE, 1FFF, 0000, 0001; data matches those locations.
- Issue cmd len=16 with st_ready toggling 1,0,0,1 and random stalls -> all 16 words in order, none lost or duplicated; data stable while stalled; ram_chipselect never issues with occupancy+inflight = 4.
- Issue cmd len=0 -> no ram_chipselect, no st_valid, done pulse 1 cycle after accept, cmd_ready back high the cycle after that.
- Assert reset after 5 of 10 beats -> all outputs take reset values immediately; a new cmd addr=0x0100, len=2 afterwards returns RAM[0x100] and RAM[0x101] with a fresh sop.
- Issue cmd len=8192 with st_ready=1 -> 8192 beats back-to-back with no gaps and exactly one sop and one eop.

Source files
------------

// File: rtl/ocram_pkg.sv
// Shared constants and FSM encoding for the on-chip RAM stream reader.
// Imported by the reader top and its FIFO.
package ocram_pkg;

  localparam int OCRAM_ADDR_W = 13;
  localparam int OCRAM_DATA_W = 16;
  localparam int OCRAM_DEPTH  = 8192;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/ocram_sync_fifo.sv
// Small synchronous FIFO holding read words with their packet tags.
// Reports occupancy so the reader can issue against free credits.
module ocram_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

endmodule

// File: rtl/ocram_stream_reader.sv
// Command-driven read engine streaming RAM words out with sop/eop.
// Reads issue only while FIFO occupancy plus the in-flight word has room.
module ocram_stream_reader
  import ocram_pkg::*;
#(
  parameter int ADDR_W     = OCRAM_ADDR_W,
  parameter int DATA_W     = OCRAM_DATA_W,
  parameter int LEN_W      = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_sop,
  output logic                st_eop,
  output logic                busy,
  output logic                done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = DATA_W + 2;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic              first;
  logic              inflight;
  logic              infl_sop;
  logic              infl_eop;

  logic              accept;
  logic              issue;
  logic              last_issue;
  logic              pop;
  logic              drained;
  logic [CW:0]       occ;

  logic [FW-1:0]     fifo_wdata;
  logic [FW-1:0]     fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  assign cmd_ready  = (state == IDLE);
  assign accept     = cmd_valid & cmd_ready;
  assign occ        = {1'b0, fifo_count} + (CW+1)'(inflight);
  assign issue      = (state == READ) && (occ < (CW+1)'(FIFO_DEPTH));
  assign last_issue = issue && (remaining == LEN_W'(1));
  assign pop        = !fifo_empty && st_ready;

  // Leave DRAIN on the same edge that pops the final word.
  assign drained = !inflight &&
                   (fifo_empty || (fifo_count == CW'(1) && pop));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nx = (cmd_len == '0) ? DONE : READ;
      end
      READ: begin
        if (last_issue) state_nx = DRAIN;
      end
      DRAIN: begin
        if (drained) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr  <= '0;
      remaining <= '0;
      first     <= 1'b0;
      inflight  <= 1'b0;
      infl_sop  <= 1'b0;
      infl_eop  <= 1'b0;
    end else begin
      if (accept) begin
        cur_addr  <= cmd_addr;
        remaining <= cmd_len;
        first     <= 1'b1;
      end else if (issue) begin
        cur_addr  <= cur_addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
        first     <= 1'b0;
      end
      inflight <= issue;
      infl_sop <= issue & first;
      infl_eop <= last_issue;
    end
  end

  assign fifo_wdata = {infl_sop, infl_eop, ram_readdata};

  ocram_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign st_valid = !fifo_empty;
  assign st_data  = fifo_rdata[DATA_W-1:0];
  assign st_eop   = fifo_rdata[DATA_W]   & !fifo_empty;
  assign st_sop   = fifo_rdata[DATA_W+1] & !fifo_empty;

  assign ram_chipselect = issue;
  assign ram_address    = issue ? cur_addr : '0;
  assign ram_write      = 1'b0;
  assign ram_byteenable = '1;
  assign ram_clken      = 1'b1;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_ocram_stream_reader.sv
// Scoreboard bench for the RAM stream reader with a behavioural RAM.
// Driver queues expected addresses and beats; a negedge monitor checks them.
module tb_ocram_stream_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [12:0] cmd_addr;
  logic [13:0] cmd_len;
  logic [12:0] ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic [1:0]  ram_byteenable;
  logic        ram_clken;
  logic [15:0] ram_readdata;
  logic [15:0] st_data;
  logic        st_valid;
  logic        st_ready;
  logic        st_sop;
  logic        st_eop;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  ocram_stream_reader dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_byteenable (ram_byteenable),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_sop         (st_sop),
    .st_eop         (st_eop),
    .busy           (busy),
    .done           (done)
  );

  logic [15:0] mem [8192];

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i) ^ 16'hA5A5;
  end

  always @(posedge clk) begin
    if (ram_chipselect) ram_readdata <= mem[ram_address];
  end

  typedef struct packed {
    logic [15:0] d;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t       exp_q[$];
  logic [12:0] addr_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event want none", nm);
  endtask

  // st_ready pattern source
  int stall_mode = 0;
  int rdy_idx = 0;
  logic [3:0] rdy_pat = 4'b1001;

  initial begin
    st_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode != 0) begin
        if (rdy_idx < 4) st_ready = rdy_pat[3 - rdy_idx];
        else             st_ready = 1'($urandom_range(0, 1));
        rdy_idx++;
      end else begin
        st_ready = 1'b1;
      end
    end
  end

  // Monitor
  int    outstanding = 0;
  bit    stalled = 0;
  logic [17:0] held;
  int    first_valid = -1;
  int    first_beat = -1;
  int    last_beat = -1;
  int    beats = 0;
  beat_t e;

  always @(negedge clk) begin
    if (reset) begin
      outstanding = 0;
      stalled = 0;
    end else begin
      if (ram_chipselect) begin
        chk("occupancy_lt_depth", 32'(outstanding < 4), 32'd1);
        if (addr_q.size() == 0) fail("unexpected_issue");
        else chk("ram_address", 32'(ram_address), 32'(addr_q.pop_front()));
      end
      if (stalled) begin
        chk("stall_valid", 32'(st_valid), 32'd1);
        chk("stall_hold", 32'({st_data, st_sop, st_eop}), 32'(held));
      end
      if (st_valid && first_valid < 0) first_valid = cyc;
      if (st_valid && st_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_beat");
        end else begin
          e = exp_q.pop_front();
          chk("beat", 32'({st_data, st_sop, st_eop}), 32'(e));
        end
        beats++;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
      end
      stalled = st_valid && !st_ready;
      held = {st_data, st_sop, st_eop};
      outstanding = outstanding + int'(ram_chipselect) -
                    int'(st_valid && st_ready);
    end
  end

  int acc_cyc;
  int done_cyc;

  task automatic send(input logic [12:0] a, input logic [13:0] l,
                      input bit model);
    logic [12:0] ad;
    for (int k = 0; k < int'(l); k++) begin
      ad = 13'(int'(a) + k);
      addr_q.push_back(ad);
      if (model)
        exp_q.push_back(beat_t'{d: mem[ad], sop: (k == 0),
                                eop: (k == int'(l) - 1)});
    end
    first_valid = -1;
    first_beat = -1;
    last_beat = -1;
    beats = 0;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_len = l;
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (done_cyc < 0) fail("done_timeout");
  endtask

  task automatic post_done(input string nm);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
    chk({nm, "_ready_back"}, 32'(cmd_ready), 32'd1);
    chk({nm, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_addr_left"}, 32'(addr_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({nm, "_st_valid"}, 32'(st_valid), 32'd0);
    chk({nm, "_sop_eop"}, 32'({st_sop, st_eop}), 32'd0);
    chk({nm, "_busy_done"}, 32'({busy, done}), 32'd0);
    chk({nm, "_chipselect"}, 32'(ram_chipselect), 32'd0);
    chk({nm, "_address"}, 32'(ram_address), 32'd0);
    chk({nm, "_ties"}, 32'({ram_write, ram_byteenable, ram_clken}),
        32'b0111);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);

    // Basic 4-word read, hand-computed data
    exp_q.push_back(beat_t'{d: 16'hA5B5, sop: 1'b1, eop: 1'b0});
    exp_q.push_back(beat_t'{d: 16'hA5B4, sop: 1'b0, eop: 1'b0});
    exp_q.push_back(beat_t'{d: 16'hA5B7, sop: 1'b0, eop: 1'b0});
    exp_q.push_back(beat_t'{d: 16'hA5B6, sop: 1'b0, eop: 1'b1});
    send(13'h0010, 14'd4, 1'b0);
    wait_done(50);
    chk("t1_first_valid", 32'(first_valid - acc_cyc), 32'd3);
    chk("t1_done_after_last", 32'(done_cyc - last_beat), 32'd1);
    chk("t1_beats", 32'(beats), 32'd4);
    post_done("t1");

    // Address wrap at the top of the RAM
    send(13'h1FFE, 14'd4, 1'b1);
    wait_done(50);
    chk("t2_beats", 32'(beats), 32'd4);
    chk("t2_done_after_last", 32'(done_cyc - last_beat), 32'd1);
    post_done("t2");

    // Backpressure with stalls
    rdy_idx = 0;
    stall_mode = 1;
    send(13'h0200, 14'd16, 1'b1);
    wait_done(600);
    stall_mode = 0;
    chk("t3_beats", 32'(beats), 32'd16);
    post_done("t3");

    // Zero-length command
    send(13'h0040, 14'd0, 1'b1);
    wait_done(10);
    chk("t4_done_lat", 32'(done_cyc - acc_cyc), 32'd1);
    chk("t4_ready_low", 32'(cmd_ready), 32'd0);
    chk("t4_no_valid", 32'(first_valid), 32'hFFFFFFFF);
    post_done("t4");

    // Reset mid-command
    send(13'h0300, 14'd10, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (beats >= 5) break;
    end
    chk("t5_beats_before_rst", 32'(beats), 32'd5);
    #1 reset = 1'b1;
    #1;
    chk_reset_outputs("t5_rst");
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(beat_t'{d: 16'hA4A5, sop: 1'b1, eop: 1'b0});
    exp_q.push_back(beat_t'{d: 16'hA4A4, sop: 1'b0, eop: 1'b1});
    send(13'h0100, 14'd2, 1'b0);
    wait_done(50);
    chk("t5_beats_after", 32'(beats), 32'd2);
    post_done("t5");

    // Whole-RAM read with wrap
    send(13'h1000, 14'd8192, 1'b1);
    wait_done(9000);
    chk("t6_beats", 32'(beats), 32'd8192);
    chk("t6_no_gaps", 32'(last_beat - first_beat), 32'd8191);
    chk("t6_first_valid", 32'(first_valid - acc_cyc), 32'd3);
    chk("t6_done_after_last", 32'(done_cyc - last_beat), 32'd1);
    post_done("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
